// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - fetch state encoding and select-code decode shared by the operand fetch slice
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH_A,
        FETCH_B,
        DONE
    } fetch_state_t;

    localparam int SEL_ZERO  = 0;
    localparam int MAX_SEL_W = 16;

    typedef struct packed {
        logic                 is_reg;
        logic                 is_imm;
        logic                 is_err;
        logic [MAX_SEL_W-1:0] idx;
    } sel_decode_t;

    function automatic logic [MAX_SEL_W-1:0] sel_imm(input int sel_w);
        return MAX_SEL_W'((32'd1 << sel_w) - 32'd1);
    endfunction

    // Code 0 decodes to all flags clear, which the caller treats as a zero operand.
    function automatic sel_decode_t decode_sel(input logic [MAX_SEL_W-1:0] code,
                                               input int sel_w,
                                               input int num_regs);
        sel_decode_t d;
        d = '0;
        if (code != MAX_SEL_W'(SEL_ZERO)) begin
            if (int'(code) <= num_regs) begin
                d.is_reg = 1'b1;
                d.idx    = code - MAX_SEL_W'(1);
            end else if (code == sel_imm(sel_w)) begin
                d.is_imm = 1'b1;
            end else begin
                d.is_err = 1'b1;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/reg_bank.sv
// rtl/reg_bank.sv - general register bank with one write port and a bypassed combinational read
module reg_bank #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 8,
    parameter int IDX_W    = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_en && wr_idx == IDX_W'(i)) begin
                    regs[i] <= wr_data;
                end
            end
        end
    end

    // A write landing this cycle on the register being read wins over the stored value.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_data = regs[i];
            end
        end
        if (wr_en && wr_idx == rd_idx) begin
            rd_data = wr_data;
        end
    end

endmodule

// File: rtl/operand_fetch_sequencer.sv
// rtl/operand_fetch_sequencer.sv - sequences operand A/B fetches from the register bank or immediate
module operand_fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 8,
    parameter int SEL_W    = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [SEL_W-1:0]  sel_a,
    input  logic [SEL_W-1:0]  sel_b,
    input  logic [DATA_W-1:0] imm,
    input  logic              wr_en,
    input  logic [SEL_W-1:0]  wr_sel,
    input  logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic [DATA_W-1:0] operand_a,
    output logic [DATA_W-1:0] operand_b,
    output logic              valid,
    output logic              sel_err
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    fetch_state_t      state;
    logic [SEL_W-1:0]  sel_a_q;
    logic [SEL_W-1:0]  sel_b_q;
    logic [DATA_W-1:0] imm_q;

    sel_decode_t       rd_dec;
    sel_decode_t       wr_dec;
    logic [IDX_W-1:0]  rd_idx;
    logic [IDX_W-1:0]  wr_idx;
    logic              bank_wr_en;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] fetch_val;
    logic              unused_dec_bits;

    // The single read port serves operand A in FETCH_A and operand B in FETCH_B.
    always_comb begin
        rd_dec     = decode_sel(MAX_SEL_W'(state == FETCH_B ? sel_b_q : sel_a_q), SEL_W, NUM_REGS);
        wr_dec     = decode_sel(MAX_SEL_W'(wr_sel), SEL_W, NUM_REGS);
        rd_idx     = IDX_W'(rd_dec.idx);
        wr_idx     = IDX_W'(wr_dec.idx);
        bank_wr_en = wr_en & wr_dec.is_reg;
        fetch_val  = '0;
        if (rd_dec.is_reg) begin
            fetch_val = rd_data;
        end else if (rd_dec.is_imm) begin
            fetch_val = imm_q;
        end
    end

    assign unused_dec_bits = ^{rd_dec.idx[MAX_SEL_W-1:IDX_W], wr_dec.idx[MAX_SEL_W-1:IDX_W],
                               wr_dec.is_imm, wr_dec.is_err};

    reg_bank #(
        .DATA_W  (DATA_W),
        .NUM_REGS(NUM_REGS),
        .IDX_W   (IDX_W)
    ) u_reg_bank (
        .clock  (clock),
        .reset  (reset),
        .wr_en  (bank_wr_en),
        .wr_idx (wr_idx),
        .wr_data(wr_data),
        .rd_idx (rd_idx),
        .rd_data(rd_data)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            valid     <= 1'b0;
            sel_err   <= 1'b0;
            operand_a <= '0;
            operand_b <= '0;
            sel_a_q   <= '0;
            sel_b_q   <= '0;
            imm_q     <= '0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sel_a_q <= sel_a;
                        sel_b_q <= sel_b;
                        imm_q   <= imm;
                        sel_err <= 1'b0;
                        busy    <= 1'b1;
                        state   <= FETCH_A;
                    end
                end
                FETCH_A: begin
                    operand_a <= fetch_val;
                    sel_err   <= rd_dec.is_err;
                    state     <= FETCH_B;
                end
                FETCH_B: begin
                    operand_b <= fetch_val;
                    sel_err   <= sel_err | rd_dec.is_err;
                    valid     <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
